// File: rtl/not_gate_pkg.sv
// rtl/not_gate_pkg.sv - shared state encodings and constants for the inverter BIST
package not_gate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Smallest usable settle time; a vector must be held at least one cycle.
   localparam int SETTLE_MIN = 1;

endpackage

// File: rtl/bist_settle_timer.sv
// rtl/bist_settle_timer.sv - settle-time down-counter for the inverter BIST
module bist_settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic last
);

   localparam int CW = $clog2(SETTLE + 1);

   logic [CW-1:0] cnt;

   // Load the settle time for a fresh vector, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(SETTLE);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == CW'(1));

endmodule

// File: rtl/not_gate_bist_ctrl.sv
// rtl/not_gate_bist_ctrl.sv - BIST sequencer that sweeps and checks an inverter
module not_gate_bist_ctrl
   import not_gate_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] dut_a,
   input  logic [WIDTH-1:0] dut_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH:0]   err_count,
   output logic [WIDTH-1:0] first_fail_vec
);

   localparam int              SETTLE_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
   localparam logic [WIDTH-1:0] ALL_ONES  = '1;

   state_t state;
   state_t state_nx;
   logic   settle_last;
   logic   timer_load;
   logic   last_vec;
   logic   mismatch;

   assign last_vec   = (dut_a == ALL_ONES);
   assign mismatch   = (dut_y != ~dut_a);
   assign timer_load = ((state == ST_IDLE) && start) || ((state == ST_CHECK) && !last_vec);

   bist_settle_timer #(
      .SETTLE (SETTLE_EFF)
   ) u_settle (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (timer_load),
      .dec   (state == ST_WAIT),
      .last  (settle_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode: sweep vectors until the all-ones vector has been checked.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_WAIT;
         ST_WAIT:  if (settle_last) state_nx = ST_CHECK;
         ST_CHECK: state_nx = last_vec ? ST_DONE : ST_WAIT;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Status flags decode straight from the state register, so they are glitch-free.
   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   // Vector counter, error tally and verdict; dut_a leaves the block straight from this flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dut_a          <= '0;
         err_count      <= '0;
         first_fail_vec <= '0;
         pass           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  dut_a          <= '0;
                  err_count      <= '0;
                  first_fail_vec <= '0;
                  pass           <= 1'b0;
               end
            end
            ST_CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + (WIDTH+1)'(1);
                  if (err_count == '0) begin
                     first_fail_vec <= dut_a;
                  end
               end
               if (!last_vec) begin
                  dut_a <= dut_a + 1'b1;
               end
            end
            ST_DONE: begin
               pass <= (err_count == '0);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_not_gate_bist_ctrl.sv
// tb/tb_not_gate_bist_ctrl.sv - self-checking bench for the inverter BIST sequencer
module tb_not_gate_bist_ctrl;

   localparam int W = 4;
   localparam int S = 2;
   localparam int N = 1 << W;
   localparam int L = N * (S + 1) + 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   dut_a;
   logic [W-1:0]   dut_y;
   logic           busy;
   logic           done;
   logic           pass;
   logic [W:0]     err_count;
   logic [W-1:0]   first_fail_vec;

   logic [W-1:0]   fy [N];
   logic [W-1:0]   noise = '0;
   int             k = 0;
   int             errors = 0;
   int             checks = 0;

   always #5 clk = ~clk;

   not_gate_bist_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .dut_a          (dut_a),
      .dut_y          (dut_y),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_fail_vec (first_fail_vec)
   );

   // The inverter under test; outside its check cycle its output is scrambled, which must not matter.
   assign dut_y = fy[dut_a] ^ (((k >= 1) && (k < L) && (k % (S + 1) == 0)) ? '0 : noise);

   always @(posedge clk) noise <= W'($urandom);

   // Run offset model: k=0 after reset, 1..L during a run (L = done cycle), L+1 idle after a run.
   always @(posedge clk) begin
      if (!rst_n)                 k <= 0;
      else if (k == 0 || k == L + 1) begin
         if (start)               k <= 1;
      end else                    k <= k + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit fails(input int v);
      logic [W-1:0] vv;
      vv = W'(v);
      return fy[v] != ~vv;
   endfunction

   // Vector v is checked in offset (v+1)*(S+1); its result is visible from the next offset.
   function automatic int exp_err(input int kk);
      int n = 0;
      for (int v = 0; v < N; v++)
         if ((v + 1) * (S + 1) < kk && fails(v)) n++;
      return n;
   endfunction

   function automatic int exp_first(input int kk);
      for (int v = 0; v < N; v++)
         if ((v + 1) * (S + 1) < kk && fails(v)) return v;
      return 0;
   endfunction

   function automatic int exp_a(input int kk);
      if (kk == 0) return 0;
      if (kk >= L) return N - 1;
      return (kk - 1) / (S + 1);
   endfunction

   // Per-cycle comparison of every output against the model.
   always begin
      @(posedge clk);
      #1;
      check("busy",  busy,  (k >= 1 && k <= L) ? 1 : 0);
      check("done",  done,  (k == L) ? 1 : 0);
      check("dut_a", dut_a, exp_a(k));
      check("err_count", err_count, exp_err(k));
      check("first_fail_vec", first_fail_vec, exp_first(k));
      check("pass",  pass,  (k == L + 1 && exp_err(k) == 0) ? 1 : 0);
   end

   // mode 0 inverter, 1 stuck-at-0, 2 buffer, 3 inverter with y=0 at vector fa, 4 random faults
   task automatic set_table(input int mode, input int fa);
      logic [W-1:0] vv;
      for (int v = 0; v < N; v++) begin
         vv = W'(v);
         case (mode)
            1:       fy[v] = '0;
            2:       fy[v] = vv;
            3:       fy[v] = (v == fa) ? '0 : ~vv;
            4:       fy[v] = ($urandom_range(0, 3) == 0) ? W'($urandom) : ~vv;
            default: fy[v] = ~vv;
         endcase
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic run(input int mode, input int fa, output int lat);
      @(negedge clk);
      set_table(mode, fa);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int n;
      set_table(0, 0);
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_err", err_count, 0);
      check("rst_a", dut_a, 0);
      rst_n = 1'b1;

      run(0, 0, lat);
      check("t1_latency", lat, 49);
      check("t1_pass", pass, 1);
      check("t1_err", err_count, 0);

      run(1, 0, lat);
      check("t2_err", err_count, 15);
      check("t2_first", first_fail_vec, 0);
      check("t2_pass", pass, 0);

      run(2, 0, lat);
      check("t3_latency", lat, 49);
      check("t3_err", err_count, 16);
      check("t3_first", first_fail_vec, 0);
      check("t3_pass", pass, 0);

      run(3, 10, lat);
      check("t4_err", err_count, 1);
      check("t4_first", first_fail_vec, 10);
      check("t4_pass", pass, 0);

      // Mid-run start ignored, then start held across done restarts immediately.
      @(negedge clk);
      set_table(2, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (k < L - 4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      start = 1'b1;
      wait_done(lat);
      repeat (2) @(negedge clk);
      check("t5_restart_busy", busy, 1);
      check("t5_restart_err", err_count, 0);
      start = 1'b0;
      wait_done(lat);
      @(negedge clk);
      check("t5_err", err_count, 16);

      // Reset during the settle wait of vector 2.
      @(negedge clk);
      set_table(2, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (k != 7 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_err_before", err_count, 2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_busy", busy, 0);
      check("t6_err", err_count, 0);
      check("t6_a", dut_a, 0);
      repeat (3) @(negedge clk);
      run(0, 0, lat);
      check("t6_pass", pass, 1);

      for (int r = 0; r < 6; r++) run(4, 0, lat);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
